// File: rtl/cv32e40x_rf_wport_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter and its XIF result buffer.
package cv32e40x_pkg;

    typedef logic [4:0] rf_addr_t;

    typedef struct packed {
        rf_addr_t    addr;
        logic [31:0] data;
    } rf_wr_req_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_WB,
        GRANT_XIF
    } rf_wgrant_e;

endpackage

// File: rtl/cv32e40x_rf_wport_arbiter_xbuf.sv
// Small FIFO holding XIF write requests until they win the register-file write port.
// Exposes per-entry valid/address so the top can compare pending destinations against reads.
module cv32e40x_rf_xbuf
    import cv32e40x_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1,
    localparam int AW = $bits(rf_addr_t)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  rf_wr_req_t          push_req,
    input  logic                pop,
    output rf_wr_req_t          head,
    output logic [CW-1:0]       count,
    output logic                empty,
    output logic [DEPTH-1:0]    entry_valid,
    output logic [DEPTH*AW-1:0] entry_addr
);

    rf_wr_req_t    mem [DEPTH];
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    // Payload storage needs no reset: validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_req;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_next;
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign empty = (count_reg == '0);

    // An entry is live when its distance from the read pointer is below the fill level.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PW-1:0] offset;
            assign offset                    = PW'(gi) - rd_ptr_reg;
            assign entry_valid[gi]           = ({1'b0, offset} < count_reg);
            assign entry_addr[gi*AW +: AW]   = mem[gi].addr;
        end
    endgenerate

endmodule

// File: rtl/cv32e40x_rf_wport_arbiter.sv
// Arbitrates the register-file write port between WB and buffered XIF results.
// Optional statistics counters are enabled with CV32E40X_RF_ARB_STATS_EN.
module cv32e40x_rf_wport_arbiter
    import cv32e40x_pkg::*;
#(
    parameter int REGFILE_NUM_READ_PORTS = 2,
    parameter int XBUF_DEPTH             = 2,
    parameter int STARVE_MAX             = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wb_valid_i,
    output logic                              wb_ready_o,
    input  rf_addr_t                          wb_waddr_i,
    input  logic [31:0]                       wb_wdata_i,
    input  logic                              x_valid_i,
    output logic                              x_ready_o,
    input  rf_addr_t                          x_waddr_i,
    input  logic [31:0]                       x_wdata_i,
    input  logic [REGFILE_NUM_READ_PORTS-1:0] rf_re_i,
    input  rf_addr_t                          rf_raddr_i [REGFILE_NUM_READ_PORTS],
    output logic                              rf_we_o,
    output rf_addr_t                          rf_waddr_o,
    output logic [31:0]                       rf_wdata_o,
    output logic                              hazard_o,
    output logic                              xbuf_empty_o
`ifdef CV32E40X_RF_ARB_STATS_EN
    ,
    output logic [31:0]                       stat_forced_o,
    output logic [31:0]                       stat_xfull_o
`endif
);

    localparam int CW = $clog2(XBUF_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int AW = $bits(rf_addr_t);

    rf_wr_req_t               xb_head;
    rf_wr_req_t               wreq;
    logic [CW-1:0]            xb_count;
    logic                     xb_empty;
    logic [XBUF_DEPTH-1:0]    xb_valid;
    logic [XBUF_DEPTH*AW-1:0] xb_addr;
    logic                     xb_push;
    logic                     force_grant;
    rf_wgrant_e               grant;
    logic [SW-1:0]            starve_reg;
    logic [SW-1:0]            starve_next;

    assign x_ready_o = (xb_count < CW'(XBUF_DEPTH));
    assign xb_push   = x_valid_i & x_ready_o;

    cv32e40x_rf_xbuf #(
        .DEPTH (XBUF_DEPTH)
    ) u_xbuf (
        .clk         (clk),
        .rst         (rst),
        .push        (xb_push),
        .push_req    ({x_waddr_i, x_wdata_i}),
        .pop         (grant == GRANT_XIF),
        .head        (xb_head),
        .count       (xb_count),
        .empty       (xb_empty),
        .entry_valid (xb_valid),
        .entry_addr  (xb_addr)
    );

    assign force_grant = (starve_reg == SW'(STARVE_MAX)) && !xb_empty;
    assign wb_ready_o  = !force_grant;

    always_comb begin
        grant = GRANT_NONE;
        if (force_grant)     grant = GRANT_XIF;
        else if (wb_valid_i) grant = GRANT_WB;
        else if (!xb_empty)  grant = GRANT_XIF;
    end

    always_comb begin
        wreq = '0;
        case (grant)
            GRANT_WB:  wreq = {wb_waddr_i, wb_wdata_i};
            GRANT_XIF: wreq = xb_head;
            default:   wreq = '0;
        endcase
    end

    // x0 writes still consume the request but never reach the register file.
    assign rf_we_o      = (grant != GRANT_NONE) && (wreq.addr != '0);
    assign rf_waddr_o   = wreq.addr;
    assign rf_wdata_o   = wreq.data;
    assign xbuf_empty_o = xb_empty;

    always_comb begin
        starve_next = starve_reg;
        if (xb_empty || grant == GRANT_XIF) starve_next = '0;
        else if (starve_reg != SW'(STARVE_MAX)) starve_next = starve_reg + SW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve_reg <= '0;
        else     starve_reg <= starve_next;
    end

    // The head being popped this cycle is still compared, keeping the flag conservative.
    always_comb begin
        hazard_o = 1'b0;
        for (int p = 0; p < REGFILE_NUM_READ_PORTS; p++) begin
            for (int e = 0; e < XBUF_DEPTH; e++) begin
                if (rf_re_i[p] && xb_valid[e] && xb_addr[e*AW +: AW] == rf_raddr_i[p]
                    && xb_addr[e*AW +: AW] != '0) begin
                    hazard_o = 1'b1;
                end
            end
        end
    end

`ifdef CV32E40X_RF_ARB_STATS_EN
    logic [31:0] stat_forced_reg;
    logic [31:0] stat_xfull_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_forced_reg <= '0;
            stat_xfull_reg  <= '0;
        end else begin
            if (force_grant && stat_forced_reg != '1)
                stat_forced_reg <= stat_forced_reg + 32'd1;
            if (x_valid_i && !x_ready_o && stat_xfull_reg != '1)
                stat_xfull_reg <= stat_xfull_reg + 32'd1;
        end
    end

    assign stat_forced_o = stat_forced_reg;
    assign stat_xfull_o  = stat_xfull_reg;
`endif

endmodule
